// File: rtl/alu_sevseg_pkg.sv
// Shared opcodes, display letter codes and the seven-segment lookup for the
// switch-driven ALU display core.
package alu_sevseg_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_NOT = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_OR  = 8'h05;
    localparam logic [7:0] OP_XOR = 8'h06;

    localparam logic [3:0] LT_A = 4'hA;
    localparam logic [3:0] LT_B = 4'hB;
    localparam logic [3:0] LT_C = 4'hC;

    // Active-low {a,b,c,d,e,f,g}; codes 13..15 render as a dark digit.
    function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/alu_sevseg_core_debounce.sv
// Push-button debouncer: 2-FF synchronizer, stability counter, and a
// single-cycle pulse on each debounced rising edge.
module alu_sevseg_debounce #(
    parameter int DB_COUNT = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(DB_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed from stable for DB_COUNT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
            pulse_r  <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r   <= '0;
            pulse_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r    <= '0;
            stable_r <= sync2_r;
            pulse_r  <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            pulse_r <= 1'b0;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/alu_sevseg_core.sv
// 8-bit switch ALU with debounced load/execute buttons and a 4-digit
// multiplexed seven-segment readout. Option: ALU_SEVSEG_ZERO_BLANK_EN.
module alu_sevseg_core
    import alu_sevseg_pkg::*;
#(
    parameter int DB_COUNT  = 250000,
    parameter int REFRESH_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb1,
    input  logic       pb2,
    input  logic       pb3,
    input  logic [7:0] sw,
    output logic [7:0] led,
    output logic [3:0] anode_activate,
    output logic [6:0] led_out
);

    localparam logic [REFRESH_W-1:0] REFRESH_ONE = REFRESH_W'(1);

    logic                 load_a_s;
    logic                 load_b_s;
    logic                 exec_s;
    logic [7:0]           a_r;
    logic [7:0]           b_r;
    logic [7:0]           c_r;
    logic                 carry_r;
    logic [3:0]           letter_r;
    logic [8:0]           alu_res_s;
    logic [11:0]          bcd_s;
    logic [15:0]          disp_s;
    logic [REFRESH_W-1:0] refresh_r;
    logic [1:0]           sel_s;
    logic [3:0]           nibble_s;

    alu_sevseg_debounce #(.DB_COUNT(DB_COUNT)) u_db_a (
        .clk(clk), .rst(rst), .btn(pb1), .pulse(load_a_s)
    );
    alu_sevseg_debounce #(.DB_COUNT(DB_COUNT)) u_db_b (
        .clk(clk), .rst(rst), .btn(pb2), .pulse(load_b_s)
    );
    alu_sevseg_debounce #(.DB_COUNT(DB_COUNT)) u_db_x (
        .clk(clk), .rst(rst), .btn(pb3), .pulse(exec_s)
    );

    // Double-dabble: 9-bit binary to three packed BCD digits.
    function automatic logic [11:0] bin2bcd(input logic [8:0] bin);
        logic [20:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 9; i++) begin
            sh[12:9]  = (sh[12:9]  >= 4'd5) ? sh[12:9]  + 4'd3 : sh[12:9];
            sh[16:13] = (sh[16:13] >= 4'd5) ? sh[16:13] + 4'd3 : sh[16:13];
            sh[20:17] = (sh[20:17] >= 4'd5) ? sh[20:17] + 4'd3 : sh[20:17];
            sh = sh << 1;
        end
        return sh[20:9];
    endfunction

    // Opcode decode; only ADD can produce a carry.
    always_comb begin
        alu_res_s = 9'd0;
        case (sw)
            OP_ADD:  alu_res_s = {1'b0, a_r} + {1'b0, b_r};
            OP_SUB:  alu_res_s = {1'b0, a_r - b_r};
            OP_NOT:  alu_res_s = {1'b0, ~a_r};
            OP_AND:  alu_res_s = {1'b0, a_r & b_r};
            OP_OR:   alu_res_s = {1'b0, a_r | b_r};
            OP_XOR:  alu_res_s = {1'b0, a_r ^ b_r};
            default: alu_res_s = 9'd0;
        endcase
    end

    // Operand/result registers; load A outranks load B outranks execute.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= 8'd0;
            b_r      <= 8'd0;
            c_r      <= sw;
            carry_r  <= 1'b0;
            letter_r <= 4'h0;
        end else if (load_a_s) begin
            a_r      <= sw;
            c_r      <= sw;
            carry_r  <= 1'b0;
            letter_r <= LT_A;
        end else if (load_b_s) begin
            b_r      <= sw;
            c_r      <= sw;
            carry_r  <= 1'b0;
            letter_r <= LT_B;
        end else if (exec_s) begin
            {carry_r, c_r} <= alu_res_s;
            letter_r       <= LT_C;
        end else begin
            a_r      <= a_r;
            b_r      <= b_r;
            c_r      <= c_r;
            carry_r  <= carry_r;
            letter_r <= letter_r;
        end
    end

    // Free-running scan counter; its top two bits pick the lit digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_r <= '0;
        end else begin
            refresh_r <= refresh_r + REFRESH_ONE;
        end
    end

    assign bcd_s = bin2bcd({carry_r, c_r});

`ifdef ALU_SEVSEG_ZERO_BLANK_EN
    // Suppress leading zeros; code 4'hF decodes to a dark digit.
    always_comb begin
        disp_s = {letter_r, bcd_s};
        if (bcd_s[11:8] == 4'd0) begin
            disp_s[11:8] = 4'hF;
            if (bcd_s[7:4] == 4'd0) begin
                disp_s[7:4] = 4'hF;
            end else begin
                disp_s[7:4] = bcd_s[7:4];
            end
        end else begin
            disp_s[11:8] = bcd_s[11:8];
        end
    end
`else
    assign disp_s = {letter_r, bcd_s};
`endif

    assign sel_s = refresh_r[REFRESH_W-1 -: 2];

    // Digit select: anode[3] is the leftmost digit and shows the letter.
    always_comb begin
        anode_activate = 4'b1111;
        nibble_s       = 4'hF;
        case (sel_s)
            2'd0: begin anode_activate = 4'b0111; nibble_s = disp_s[15:12]; end
            2'd1: begin anode_activate = 4'b1011; nibble_s = disp_s[11:8];  end
            2'd2: begin anode_activate = 4'b1101; nibble_s = disp_s[7:4];   end
            2'd3: begin anode_activate = 4'b1110; nibble_s = disp_s[3:0];   end
            default: begin anode_activate = 4'b1111; nibble_s = 4'hF; end
        endcase
    end

    assign led_out = seg_lookup(nibble_s);
    assign led     = sw;

endmodule

// File: tb/tb_alu_sevseg_core.sv
// Self-checking bench for alu_sevseg_core: directed scenarios followed by
// randomized button/switch traffic against an arithmetic reference model.
module tb_alu_sevseg_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       pb1, pb2, pb3;
    logic [7:0] sw;
    wire  [7:0] led;
    wire  [3:0] anode;
    wire  [6:0] seg;

    always #5 clk = ~clk;

    alu_sevseg_core #(.DB_COUNT(4), .REFRESH_W(4)) dut (
        .clk(clk), .rst(rst), .pb1(pb1), .pb2(pb2), .pb3(pb3), .sw(sw),
        .led(led), .anode_activate(anode), .led_out(seg)
    );

    int tick;
    int n_vec = 0;
    int n_err = 0;
    int m_a, m_b, m_c, m_carry, m_letter;
    logic [6:0] seg_tab [16];

    always @(posedge clk) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected nibble shown on digit position sel (0 = leftmost).
    function automatic int digit(input int sel);
        int v, h, t, o;
        v = m_carry * 256 + m_c;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
`ifdef ALU_SEVSEG_ZERO_BLANK_EN
        if (h == 0) begin
            if (t == 0) t = 15;
            h = 15;
        end
`endif
        case (sel)
            0:       return m_letter;
            1:       return h;
            2:       return t;
            default: return o;
        endcase
    endfunction

    task automatic check_display(input string tag);
        int sel;
        logic [3:0] exp_an;
        repeat (16) begin
            @(negedge clk);
            sel = (tick / 4) % 4;
            exp_an = 4'b1000 >> sel;
            exp_an = ~exp_an;
            chk({tag, "_anode"}, {28'd0, anode}, {28'd0, exp_an});
            chk({tag, "_seg"}, {25'd0, seg}, {25'd0, seg_tab[digit(sel)]});
        end
        chk({tag, "_led"}, {24'd0, led}, {24'd0, sw});
    endtask

    task automatic model_apply(input logic [2:0] mask, input int val);
        int s;
        if (mask[0]) begin
            m_a = val; m_c = val; m_carry = 0; m_letter = 10;
        end else if (mask[1]) begin
            m_b = val; m_c = val; m_carry = 0; m_letter = 11;
        end else if (mask[2]) begin
            m_letter = 12;
            m_carry  = 0;
            case (val)
                1: begin s = m_a + m_b; m_c = s % 256; m_carry = s / 256; end
                2: m_c = (m_a - m_b + 256) % 256;
                3: m_c = 255 - m_a;
                4: m_c = m_a & m_b;
                5: m_c = m_a | m_b;
                6: m_c = m_a ^ m_b;
                default: m_c = 0;
            endcase
        end
    endtask

    // Hold the selected buttons long enough to debounce, then release fully.
    task automatic press(input logic [2:0] mask, input logic [7:0] val);
        @(negedge clk);
        sw  = val;
        pb1 = mask[0]; pb2 = mask[1]; pb3 = mask[2];
        repeat (12) @(negedge clk);
        pb1 = 1'b0; pb2 = 1'b0; pb3 = 1'b0;
        repeat (12) @(negedge clk);
        model_apply(mask, int'(val));
    endtask

    initial begin
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1111111;
        seg_tab[14] = 7'b1111111; seg_tab[15] = 7'b1111111;

        rst = 1'b1; pb1 = 1'b0; pb2 = 1'b0; pb3 = 1'b0; sw = 8'h2A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_anode", {28'd0, anode}, 32'h7);
        m_a = 0; m_b = 0; m_c = 8'h2A; m_carry = 0; m_letter = 0;
        rst = 1'b0;
        check_display("reset");

        // Long hold: sw changes mid-hold so any second pulse would show up.
        @(negedge clk);
        sw = 8'hFF; pb1 = 1'b1;
        repeat (20) @(negedge clk);
        sw = 8'h11;
        repeat (480) @(negedge clk);
        pb1 = 1'b0;
        repeat (12) @(negedge clk);
        sw = 8'hFF;
        model_apply(3'b001, 255);
        check_display("hold_a255");

        press(3'b010, 8'h03); check_display("load_b003");
        press(3'b100, 8'h01); check_display("add_c258");
        press(3'b100, 8'h02); check_display("sub_c252");
        press(3'b100, 8'h03); check_display("not_c000");
        press(3'b100, 8'h07); check_display("bad_c000");

        // Two-cycle glitch must not register.
        @(negedge clk);
        sw = 8'h55; pb1 = 1'b1;
        repeat (2) @(negedge clk);
        pb1 = 1'b0;
        repeat (20) @(negedge clk);
        check_display("glitch");

        press(3'b101, 8'h09); check_display("pb1_over_pb3");
        press(3'b110, 8'h04); check_display("pb2_over_pb3");

        for (int i = 0; i < 40; i++) begin
            int  kind;
            logic [7:0] v;
            kind = $urandom_range(0, 3);
            if (kind >= 2) begin
                v = 8'($urandom_range(0, 8));
                press(3'b100, v);
            end else begin
                v = 8'($urandom);
                press(kind == 0 ? 3'b001 : 3'b010, v);
            end
            check_display("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
